mem_arbiter: RTL

- Two-port controller that shares the single-ported 512 x 32 RAM between the instruction-fetch path and the load/store data path.
- Each port gets a request/acknowledge handshake.
- The block sequences the RAM Read/Write strobes, holds the address and write data stable, and captures the registered RAM output.
- Sits between the CPU control unit/MDR and the RAM.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data RAM arbiter.
package mem_arb_pkg;

    localparam int DEFAULT_ADDR_W = 9;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        PORT_IF,
        PORT_D
    } port_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie, grants the port opposite to the last grant.
module rr_arbiter2 import mem_arb_pkg::*; #(
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    port_e last_grant_q, last_grant_d;

    always_comb begin
        grant        = req;
        last_grant_d = last_grant_q;
        if (req == 2'b11) begin
            grant = (last_grant_q == PORT_IF) ? 2'b10 : 2'b01;
        end
        if (update && (req != 2'b00)) begin
            last_grant_d = grant[1] ? PORT_D : PORT_IF;
        end
    end

    // Reset to the loser so that RESET_PRIO wins the first tie.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_grant_q <= RESET_PRIO ? PORT_IF : PORT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported registered-output RAM between instruction fetch and load/store.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_Read,
    output logic              ram_Write,
    output logic [ADDR_W-1:0] ram_Address,
    output logic [DATA_W-1:0] ram_Mdatain,
    input  logic [DATA_W-1:0] ram_data_output,
    output logic              busy
);

    state_e            state_q, state_d;
    port_e             port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [1:0]        grant;
    logic              arb_update;

    rr_arbiter2 #(.RESET_PRIO(RESET_PRIO)) u_arb (
        .Clock  (Clock),
        .Reset  (Reset),
        .req    ({d_req, if_req}),
        .update (arb_update),
        .grant  (grant)
    );

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        arb_update = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    arb_update = 1'b1;
                    state_d    = ISSUE;
                    if (grant[1]) begin
                        port_d  = PORT_D;
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        port_d = PORT_IF;
                        we_d   = 1'b0;
                        addr_d = if_addr;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d = RESP;
                // RAM output is valid here, one edge after the strobe was sampled.
                if (!we_q) begin
                    if (port_q == PORT_IF) begin
                        if_rdata_d = ram_data_output;
                    end else begin
                        d_rdata_d = ram_data_output;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            port_q     <= PORT_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign ram_Read    = (state_q == ISSUE) && !we_q;
    assign ram_Write   = (state_q == ISSUE) && we_q;
    assign ram_Address = addr_q;
    assign ram_Mdatain = wdata_q;
    assign if_ack      = (state_q == RESP) && (port_q == PORT_IF);
    assign d_ack       = (state_q == RESP) && (port_q == PORT_D);
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign busy        = (state_q != IDLE);

endmodule
